// File: rtl/invert_seq_pkg.sv
// Shared state encoding and default geometry for the frame invert sequencer.
package invert_seq_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_N_PIX  = 65536;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } seq_state_t;

endpackage

// File: rtl/invert_seq_pipe.sv
// Two-stage valid+index delay line that follows each read through the memory
// and the inverter; clr flushes both valids without disturbing the indices.
module invert_seq_pipe #(
  parameter int IDX_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             in_valid,
  input  logic [IDX_W-1:0] in_idx,
  output logic             s1_valid,
  output logic             s2_valid,
  output logic [IDX_W-1:0] s2_idx
);

  logic [IDX_W-1:0] s1_idx;

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_idx   <= '0;
      s2_idx   <= '0;
    end else if (clr) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
    end else begin
      s1_valid <= in_valid;
      s1_idx   <= in_idx;
      s2_valid <= s1_valid;
      s2_idx   <= s1_idx;
    end
  end

endmodule

// File: rtl/invert_sequencer.sv
// Streams one frame from src_base through an external registered inverter to dst_base.
//   state    | meaning
//   ST_IDLE  | waiting for start, pix_count holds last result
//   ST_RUN   | issuing one read per cycle
//   ST_DRAIN | two cycles letting the last reads reach the write port
//   ST_DONE  | one-cycle done pulse
module invert_sequencer
  import invert_seq_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int N_PIX  = DEF_N_PIX
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_base,
  input  logic [ADDR_W-1:0] dst_base,
  output logic              busy,
  output logic              done,
  output logic              mem_rd_en,
  output logic [ADDR_W-1:0] mem_rd_addr,
  input  logic [7:0]        mem_rd_data,
  output logic [7:0]        inv_din,
  input  logic [7:0]        inv_dout,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_wr_addr,
  output logic [7:0]        mem_wr_data,
  output logic [ADDR_W:0]   pix_count
);

  localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(N_PIX - 1);

  seq_state_t        state;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [ADDR_W-1:0] idx;
  logic              drain_cnt;
  logic              pipe_clr;
  logic              s1_valid;
  logic              s2_valid;
  logic [ADDR_W-1:0] s2_idx;

  assign pipe_clr = abort && (state == ST_RUN || state == ST_DRAIN);

  invert_seq_pipe #(.IDX_W(ADDR_W)) u_pipe (
    .clk      (clk),
    .rst      (rst),
    .clr      (pipe_clr),
    .in_valid (mem_rd_en),
    .in_idx   (idx),
    .s1_valid (s1_valid),
    .s2_valid (s2_valid),
    .s2_idx   (s2_idx)
  );

  assign mem_rd_addr = src_q + idx;
  assign inv_din     = s1_valid ? mem_rd_data : 8'd0;
  assign mem_wr_en   = s2_valid;
  assign mem_wr_addr = dst_q + s2_idx;
  assign mem_wr_data = inv_dout;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      idx       <= '0;
      drain_cnt <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      pix_count <= '0;
    end else begin
      done <= 1'b0;
      // A write leaving stage 2 this cycle counts even if abort lands on the same edge.
      if (s2_valid) pix_count <= pix_count + 1'b1;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state     <= ST_RUN;
            src_q     <= src_base;
            dst_q     <= dst_base;
            idx       <= '0;
            pix_count <= '0;
            busy      <= 1'b1;
            mem_rd_en <= 1'b1;
          end
        end
        ST_RUN: begin
          if (abort) begin
            state     <= ST_IDLE;
            busy      <= 1'b0;
            mem_rd_en <= 1'b0;
          end else if ({1'b0, idx} == LAST_IDX) begin
            state     <= ST_DRAIN;
            mem_rd_en <= 1'b0;
            drain_cnt <= 1'b1;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        ST_DRAIN: begin
          if (abort) begin
            state <= ST_IDLE;
            busy  <= 1'b0;
          end else if (drain_cnt == 1'b0) begin
            state <= ST_DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
          end else begin
            drain_cnt <= drain_cnt - 1'b1;
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
